// File: rtl/cart_pkg.sv
// Shared types and constants for the Atari 2600 cartridge bank-switch mapper.
package cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROM_WAIT = 2'd1,
    ST_ACK      = 2'd2
  } cart_state_e;

  localparam logic [11:0] SC_WR_BASE = 12'h000;
  localparam logic [11:0] SC_RD_BASE = 12'h080;
  localparam int          SC_SIZE    = 128;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cart_superchip_ram.sv
// Superchip 128x8 cartridge RAM: synchronous write and registered read, no reset on contents.
module cart_superchip_ram
  import cart_pkg::*;
(
  input  logic       clock,
  input  logic       we_i,
  input  logic       re_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [SC_SIZE];
  logic [7:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_cart_mapper.sv
// Wishbone cartridge bank-switch controller mapping a 4 KiB window onto banked ROM.
// Optional Superchip RAM is enabled with the CART_SUPERCHIP_EN macro.
module wb_cart_mapper
  import cart_pkg::*;
#(
  parameter int          NUM_BANKS    = 8,
  parameter logic [11:0] HOTSPOT_BASE = 12'hFF4,
  parameter int          RESET_BANK   = 0,
  localparam int         BANK_BITS    = (clog2(NUM_BANKS) > 1) ? clog2(NUM_BANKS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [11:0]             adr_i,
  input  logic [7:0]              dat_i,
  output logic                    ack_o,
  output logic [7:0]              dat_o,
  output logic                    rom_stb_o,
  output logic [12+BANK_BITS-1:0] rom_adr_o,
  input  logic                    rom_ack_i,
  input  logic [7:0]              rom_dat_i,
  output logic [BANK_BITS-1:0]    bank_o
);

  cart_state_e             state_q, state_d;
  logic [11:0]             adr_q, adr_d;
  logic [7:0]              dat_q, dat_d;
  logic [BANK_BITS-1:0]    bank_q, bank_d;
  logic [12+BANK_BITS-1:0] rom_adr_q, rom_adr_d;
  logic                    sc_sel_q, sc_sel_d;
  logic                    sc_wr_s, sc_rd_s;
  logic [7:0]              ram_rdata_s;
  logic [12:0]             hs_off_s;
  logic                    hs_hit_s;

`ifdef CART_SUPERCHIP_EN
  logic ram_we_s, ram_re_s;

  assign sc_wr_s  = (adr_i[11:7] == SC_WR_BASE[11:7]);
  assign sc_rd_s  = (adr_i[11:7] == SC_RD_BASE[11:7]);
  assign ram_we_s = (state_q == ST_IDLE) && stb_i && we_i && sc_wr_s && !reset;
  assign ram_re_s = (state_q == ST_IDLE) && stb_i && !we_i && sc_rd_s && !reset;

  cart_superchip_ram u_ram (
    .clock  (clock),
    .we_i   (ram_we_s),
    .re_i   (ram_re_s),
    .addr_i (adr_i[6:0]),
    .wdata_i(dat_i),
    .rdata_o(ram_rdata_s)
  );
`else
  logic unused_dat_s;

  assign sc_wr_s      = 1'b0;
  assign sc_rd_s      = 1'b0;
  assign ram_rdata_s  = 8'h00;
  assign unused_dat_s = ^dat_i;
`endif

  // Widened subtraction so offsets below the base never alias into the hot-spot range.
  assign hs_off_s = {1'b0, adr_q} - {1'b0, HOTSPOT_BASE};
  assign hs_hit_s = (NUM_BANKS > 1) && (adr_q >= HOTSPOT_BASE) && (hs_off_s < 13'(NUM_BANKS));

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    bank_d    = bank_q;
    rom_adr_d = rom_adr_q;
    sc_sel_d  = sc_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (stb_i) begin
          adr_d    = adr_i;
          sc_sel_d = 1'b0;
          if (sc_wr_s) begin
            if (!we_i) dat_d = 8'hFF;
            state_d = ST_ACK;
          end else if (sc_rd_s) begin
            sc_sel_d = !we_i;
            state_d  = ST_ACK;
          end else if (we_i) begin
            state_d = ST_ACK;
          end else begin
            rom_adr_d = {bank_q, adr_i};
            state_d   = ST_ROM_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROM_WAIT: begin
        if (rom_ack_i) begin
          dat_d   = rom_dat_i;
          state_d = ST_ACK;
        end else begin
          state_d = ST_ROM_WAIT;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        // Bank switches only as the acknowledge retires, so the hot-spot access sees the old bank.
        if (hs_hit_s) bank_d = hs_off_s[BANK_BITS-1:0];
        else          bank_d = bank_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      adr_q     <= 12'h000;
      dat_q     <= 8'h00;
      bank_q    <= BANK_BITS'(RESET_BANK);
      rom_adr_q <= '0;
      sc_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      bank_q    <= bank_d;
      rom_adr_q <= rom_adr_d;
      sc_sel_q  <= sc_sel_d;
    end
  end

  assign ack_o     = (state_q == ST_ACK);
  assign rom_stb_o = (state_q == ST_ROM_WAIT);
  assign rom_adr_o = rom_adr_q;
  assign bank_o    = bank_q;
  assign dat_o     = sc_sel_q ? ram_rdata_s : dat_q;

endmodule
